muldiv_iter: RTL and testbench

- Parametrised iterative RV32M-style multiply/divide unit that extends the combinational ALU to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the ALU in the execute stage of the next-generation (multicycle) core.
- Operands enter through a valid/ready handshake. The result returns through a valid/ready handshake together with a passthrough destination tag.
- Processes one operand bit per cycle.

---
 rtl/muldiv_iter.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one operand bit per cycle, with valid/ready handshakes on both sides.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    cond_neg = n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]         state_r;
  logic [2:0]         funct3_r;
  logic               neg_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH:0]     rem_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [TAG_W-1:0]   tag_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   out_result_r;
  logic [TAG_W-1:0]   out_tag_r;

  logic               a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               div_zero_s, div_ovf_s, special_s;
  logic [WIDTH-1:0]   special_res_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s, rem_step_s;
  logic [2*WIDTH-1:0] acc_step_s, prod_s;
  logic [WIDTH-1:0]   fix_res_s;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_tag    = out_tag_r;

  // Request decode: operand signedness, magnitudes and divide special cases.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (in_funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      3'b010: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s    = a_signed_s & in_a[WIDTH-1];
    b_neg_s    = b_signed_s & in_b[WIDTH-1];
    a_mag_s    = cond_neg(in_a, a_neg_s);
    b_mag_s    = cond_neg(in_b, b_neg_s);
    div_zero_s = in_funct3[2] & (in_b == ZERO);
    div_ovf_s  = in_funct3[2] & a_signed_s & (in_a == MOST_NEG) & (in_b == ONES);
    special_s  = div_zero_s | div_ovf_s;
    special_res_s = ZERO;
    if (div_zero_s) begin
      special_res_s = in_funct3[1] ? in_a : ONES;
    end else if (div_ovf_s) begin
      special_res_s = in_funct3[1] ? ZERO : in_a;
    end else begin
      special_res_s = ZERO;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {rem_r[WIDTH-1:0], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    acc_step_s  = acc_r;
    rem_step_s  = rem_r;
    if (funct3_r[2]) begin
      // Low half of acc_r shifts the dividend out and the quotient in.
      if (!div_diff_s[WIDTH]) begin
        rem_step_s = div_diff_s;
        acc_step_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_step_s = div_shift_s;
        acc_step_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      rem_step_s = rem_r;
    end
  end

  // Final sign correction and result selection.
  always_comb begin
    prod_s = neg_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    case (funct3_r)
      3'b000:                 fix_res_s = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res_s = cond_neg(acc_r[WIDTH-1:0], neg_r);
      3'b110, 3'b111:         fix_res_s = cond_neg(rem_r[WIDTH-1:0], neg_r);
      default:                fix_res_s = ZERO;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      funct3_r     <= 3'b000;
      neg_r        <= 1'b0;
      opnd_r       <= ZERO;
      acc_r        <= {(2*WIDTH){1'b0}};
      rem_r        <= {(WIDTH+1){1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      tag_r        <= {TAG_W{1'b0}};
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_result_r <= ZERO;
      out_tag_r    <= {TAG_W{1'b0}};
    end else if (flush) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            funct3_r   <= in_funct3;
            tag_r      <= in_tag;
            neg_r      <= (in_funct3[2] & in_funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
            cnt_r      <= {CNT_W{1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            in_ready_r <= 1'b0;
            if (special_s) begin
              out_result_r <= special_res_s;
              out_tag_r    <= in_tag;
              out_valid_r  <= 1'b1;
              state_r      <= S_DONE;
            end else begin
              opnd_r  <= in_funct3[2] ? b_mag_s : a_mag_s;
              acc_r   <= {ZERO, (in_funct3[2] ? a_mag_s : b_mag_s)};
              state_r <= S_CALC;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_r <= acc_step_s;
          rem_r <= rem_step_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIX: begin
          out_result_r <= fix_res_s;
          out_tag_r    <= tag_r;
          out_valid_r  <= 1'b1;
          state_r      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter (WIDTH=32) with hand-computed results.
module tb_muldiv_iter;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    in_funct3;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [TW-1:0] in_tag, out_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request before an edge; returns #1 after the accepting edge.
  task automatic start_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] t);
    @(negedge clk);
    check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_funct3 = f; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 32'hDEADBEEF; in_b = 32'h0BADF00D; in_funct3 = 3'b101; in_tag = 5'd31;
  endtask

  // Count edges (accepting edge is edge 1) until out_valid; bounded.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] t,
                       input logic [W-1:0] exp, input int exp_lat);
    int edges;
    start_op(name, f, a, b, t);
    wait_valid(edges);
    check({name, " latency"}, 32'(edges), 32'(exp_lat));
    check({name, " result"}, out_result, exp);
    check({name, " tag"}, {27'b0, out_tag}, {27'b0, t});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int edges;
    int pulses;
    logic [W-1:0] held;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct3 = 3'b000; in_a = 32'h0; in_b = 32'h0; in_tag = 5'd0;
    #12;
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_result", out_result, 32'h0);
    check("rst out_tag", {27'b0, out_tag}, 32'h0);
    @(negedge clk); reset = 1'b1;

    do_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 34);
    do_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 34);
    do_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 34);
    do_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, 34);
    do_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 34);
    do_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 34);
    do_op("divu",   3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       34);
    do_op("remu",   3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        34);
    do_op("divu0",  3'b101, 32'h1234,     32'h0,        5'd11, 32'hFFFFFFFF, 1);
    do_op("remu0",  3'b111, 32'h1234,     32'h0,        5'd12, 32'h00001234, 1);
    do_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1);
    do_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h0,        1);

    // Backpressure: hold DONE for 10 cycles while a competing request is offered
    start_op("bp", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd3);
    wait_valid(edges);
    check("bp result", out_result, 32'hFFFFFFEB);
    held = out_result;
    in_valid = 1'b1; in_funct3 = 3'b101; in_a = 32'd50; in_b = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp stable", out_result, held);
      check("bp in_ready", {31'b0, in_ready}, 32'd0);
      check("bp out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release in_ready", {31'b0, in_ready}, 32'd1);
    check("bp release out_valid", {31'b0, out_valid}, 32'd0);
    do_op("bp next", 3'b101, 32'd100, 32'd7, 5'd2, 32'd14, 34);

    // Flush during the fifth CALC cycle
    start_op("flush", 3'b101, 32'd100, 32'd7, 5'd9);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", {31'b0, in_ready}, 32'd1);
    check("flush out_valid", {31'b0, out_valid}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("flush no pulse", 32'(pulses), 32'd0);
    do_op("post flush", 3'b000, 32'd6, 32'd9, 5'd1, 32'd54, 34);

    // Asynchronous reset mid-CALC
    start_op("rst mid", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20);
    repeat (10) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    check("rst mid in_ready", {31'b0, in_ready}, 32'd1);
    check("rst mid out_valid", {31'b0, out_valid}, 32'd0);
    check("rst mid out_result", out_result, 32'h0);
    check("rst mid out_tag", {27'b0, out_tag}, 32'h0);
    @(negedge clk); reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("rst mid no pulse", 32'(pulses), 32'd0);
    do_op("post rst", 3'b101, 32'd100, 32'd7, 5'd17, 32'd14, 34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
